// File: rtl/branch_pkg.sv
// Shared types and constants for PC redirection between EX and fetch.
package branch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam int RV_XLEN = 32;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
  } redirect_t;

  localparam logic [1:0] ALIGN_MASK_RV32I  = 2'b11;
  localparam logic [1:0] ALIGN_MASK_RV32IC = 2'b01;

  function automatic logic is_aligned(input logic [1:0] pc_lsb, input logic [1:0] mask);
    return (pc_lsb & mask) == 2'b00;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Wrapping event counter with synchronous clear taking priority over increment.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a taken EX-stage control-flow result into one redirect request plus
// IF/ID and ID/EX flushes, holding it until fetch accepts.
//
// state | meaning
// IDLE  | no redirect outstanding; a taken aligned branch redirects combinationally
// PEND  | redirect issued but not yet accepted; replayed from the latched PC
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter int         CNT_W      = 32,
  parameter logic [1:0] ALIGN_MASK = ALIGN_MASK_RV32I
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_cf,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_pc_branch,
  input  logic             i_pipe_stall,
  input  logic             i_fetch_ready,
  input  logic             i_cnt_clr,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_fetch_hold,
  output logic             o_misalign,
  output logic [XLEN-1:0]  o_misalign_pc,
  output logic [CNT_W-1:0] o_cnt_cf,
  output logic [CNT_W-1:0] o_cnt_taken
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_fired;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_pc;

  logic w_event;
  logic w_aligned;
  logic w_retire;
  logic w_idle_issue;
  logic w_idle_trap;

  // r_fired masks the replays of a stalled instruction that already redirected.
  assign w_event      = i_ex_valid & i_branch_taken & ~r_fired;
  assign w_aligned    = is_aligned(i_pc_branch[1:0], ALIGN_MASK);
  assign w_retire     = i_ex_valid & ~i_pipe_stall;
  assign w_idle_issue = (r_state == IDLE) & w_event & w_aligned;
  assign w_idle_trap  = (r_state == IDLE) & w_event & ~w_aligned;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          r_fired <= 1'b0;
    else if (!i_pipe_stall) r_fired <= 1'b0;
    else if (w_event)      r_fired <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_pend_pc <= '0;
    else if (w_idle_issue && !i_fetch_ready) r_pend_pc <= i_pc_branch;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign    <= 1'b0;
      r_misalign_pc <= '0;
    end else begin
      r_misalign <= w_idle_trap;
      if (w_idle_trap) r_misalign_pc <= i_pc_branch;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_flush_if_id    = 1'b0;
    o_flush_id_ex    = 1'b0;
    o_fetch_hold     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_idle_issue) begin
          o_redirect_valid = 1'b1;
          o_redirect_pc    = i_pc_branch;
          o_flush_if_id    = 1'b1;
          o_flush_id_ex    = 1'b1;
          if (!i_fetch_ready) w_state_nxt = PEND;
        end
      end
      PEND: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_pend_pc;
        o_flush_if_id    = 1'b1;
        o_flush_id_ex    = 1'b1;
        o_fetch_hold     = 1'b1;
        if (i_fetch_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_misalign    = r_misalign;
  assign o_misalign_pc = r_misalign_pc;

  perf_counter #(.W(CNT_W)) u_cnt_cf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (w_retire & i_ex_is_cf),
    .o_cnt   (o_cnt_cf)
  );

  perf_counter #(.W(CNT_W)) u_cnt_taken (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (w_retire & i_ex_is_cf & i_branch_taken & w_aligned),
    .o_cnt   (o_cnt_taken)
  );

  // EX should hold a bubble while a redirect is pending; a new taken branch here is dropped.
  a_no_event_in_pend: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == PEND) |-> !w_event);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus randomized checking of branch_redirect_ctrl against a behavioural model.
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_is_cf;
  logic             branch_taken;
  logic [XLEN-1:0]  pc_branch;
  logic             pipe_stall;
  logic             fetch_ready;
  logic             cnt_clr;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             fetch_hold;
  logic             misalign;
  logic [XLEN-1:0]  misalign_pc;
  logic [CNT_W-1:0] cnt_cf;
  logic [CNT_W-1:0] cnt_taken;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .ALIGN_MASK(2'b11)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ex_valid       (ex_valid),
    .i_ex_is_cf       (ex_is_cf),
    .i_branch_taken   (branch_taken),
    .i_pc_branch      (pc_branch),
    .i_pipe_stall     (pipe_stall),
    .i_fetch_ready    (fetch_ready),
    .i_cnt_clr        (cnt_clr),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_flush_if_id    (flush_if_id),
    .o_flush_id_ex    (flush_id_ex),
    .o_fetch_hold     (fetch_hold),
    .o_misalign       (misalign),
    .o_misalign_pc    (misalign_pc),
    .o_cnt_cf         (cnt_cf),
    .o_cnt_taken      (cnt_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: is a redirect outstanding, which target, did the stalled instruction already fire
  bit          m_pend;
  logic [31:0] m_pc;
  bit          m_fired;
  bit          m_mis;
  logic [31:0] m_mis_pc;
  int          m_cf;
  int          m_tk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pend = 0; m_pc = '0; m_fired = 0; m_mis = 0; m_mis_pc = '0; m_cf = 0; m_tk = 0;
  endtask

  task automatic drv(input logic v, input logic cf, input logic tk, input logic [31:0] p,
                     input logic st, input logic rd);
    ex_valid = v; ex_is_cf = cf; branch_taken = tk; pc_branch = p;
    pipe_stall = st; fetch_ready = rd;
  endtask

  task automatic idle_in();
    drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cnt_clr = 1'b0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    bit          ev, al, erv, efl, ehold;
    logic [31:0] epc;
    bit          n_mis;
    #1;
    ev    = ex_valid && branch_taken && !m_fired;
    al    = (pc_branch % 4) == 0;
    erv   = 0; efl = 0; ehold = 0; epc = '0;
    if (m_pend) begin
      erv = 1; efl = 1; ehold = 1; epc = m_pc;
    end else if (ev && al) begin
      erv = 1; efl = 1; epc = pc_branch;
    end
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, erv});
    chk("redirect_pc",    redirect_pc, epc);
    chk("flush_if_id",    {31'b0, flush_if_id}, {31'b0, efl});
    chk("flush_id_ex",    {31'b0, flush_id_ex}, {31'b0, efl});
    chk("fetch_hold",     {31'b0, fetch_hold},  {31'b0, ehold});

    n_mis = !m_pend && ev && !al;
    if (n_mis) m_mis_pc = pc_branch;
    m_mis = n_mis;
    if (m_pend) begin
      if (fetch_ready) m_pend = 0;
    end else if (ev && al && !fetch_ready) begin
      m_pend = 1; m_pc = pc_branch;
    end
    m_fired = pipe_stall ? (m_fired || (ex_valid && branch_taken)) : 0;
    if (cnt_clr) begin
      m_cf = 0; m_tk = 0;
    end else if (ex_valid && !pipe_stall) begin
      if (ex_is_cf) m_cf = (m_cf + 1) % 256;
      if (ex_is_cf && branch_taken && al) m_tk = (m_tk + 1) % 256;
    end

    @(posedge clk); #1;
    chk("misalign",    {31'b0, misalign}, {31'b0, m_mis});
    chk("misalign_pc", misalign_pc, m_mis_pc);
    chk("cnt_cf",      {24'b0, cnt_cf}, m_cf[31:0]);
    chk("cnt_taken",   {24'b0, cnt_taken}, m_tk[31:0]);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rv"},    {31'b0, redirect_valid}, 32'h0);
    chk({tag, "_pc"},    redirect_pc, 32'h0);
    chk({tag, "_fl"},    {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    chk({tag, "_hold"},  {31'b0, fetch_hold}, 32'h0);
    chk({tag, "_mis"},   {31'b0, misalign}, 32'h0);
    chk({tag, "_mispc"}, misalign_pc, 32'h0);
    chk({tag, "_cf"},    {24'b0, cnt_cf}, 32'h0);
    chk({tag, "_tk"},    {24'b0, cnt_taken}, 32'h0);
  endtask

  initial begin
    bit          prev_stall;
    logic        r_v, r_cf, r_tk;
    logic [31:0] r_pc;

    rst_n = 1'b0;
    idle_in();
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // taken BEQ, fetch ready, no stall
    drv(1, 1, 1, 32'h100, 0, 1); cycle();
    chk("t1_cnt_cf", {24'b0, cnt_cf}, 32'd1);
    chk("t1_cnt_tk", {24'b0, cnt_taken}, 32'd1);
    idle_in(); cycle();

    // taken JAL, fetch not ready for 3 cycles
    drv(1, 1, 1, 32'h200, 0, 0); cycle();
    drv(0, 0, 0, 32'h0, 0, 0); cycle(); cycle();
    drv(0, 0, 0, 32'h0, 0, 1); cycle();
    idle_in(); cycle();

    // taken JALR stalled twice
    drv(1, 1, 1, 32'h300, 1, 1); cycle(); cycle();
    drv(1, 1, 1, 32'h300, 0, 1); cycle();
    chk("t3_cnt_cf", {24'b0, cnt_cf}, 32'd3);
    idle_in(); cycle();

    // misaligned target
    drv(1, 1, 1, 32'h102, 0, 1); cycle();
    chk("t4_misalign_pc", misalign_pc, 32'h102);
    idle_in(); cycle();

    // not-taken BNE then ADD
    drv(1, 1, 0, 32'h400, 0, 1); cycle();
    drv(1, 0, 0, 32'h0, 0, 1); cycle();
    idle_in(); cycle();

    // reset asserted while a redirect is pending
    drv(1, 1, 1, 32'h500, 0, 0); cycle();
    idle_in(); fetch_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_pend");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    cycle();

    // counter wrap with clear priority over increment
    drv(1, 1, 1, 32'h600, 0, 1); cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drv(1, 1, 1, 32'h1000 + 32'(i) * 4, 0, 1); cycle();
    end
    chk("wrap_pre", {24'b0, cnt_taken}, 32'hFF);
    drv(1, 1, 1, 32'h2000, 0, 1); cycle();
    chk("wrap_post", {24'b0, cnt_taken}, 32'h0);
    idle_in(); cycle();

    // randomized traffic; a stalled instruction is replayed unchanged
    prev_stall = 0;
    r_v = 0; r_cf = 0; r_tk = 0; r_pc = '0;
    for (int i = 0; i < 600; i++) begin
      if (!prev_stall) begin
        r_v  = ($urandom_range(0, 3) != 0);
        r_cf = ($urandom_range(0, 2) != 0);
        r_tk = r_cf && ($urandom_range(0, 1) != 0);
        r_pc = $urandom;
        if ($urandom_range(0, 9) < 7) r_pc[1:0] = 2'b00;
      end
      drv(m_pend ? 1'b0 : r_v, r_cf, r_tk, r_pc,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6));
      cnt_clr = ($urandom_range(0, 39) == 0);
      prev_stall = pipe_stall;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
